// File: rtl/player_pkg.sv
// Shared types for the grid player controller: headings, FSM states, key bit
// indices and the per-heading step delta.
package player_pkg;

  typedef enum logic [1:0] {
    DIR_E = 2'd0,
    DIR_N = 2'd1,
    DIR_W = 2'd2,
    DIR_S = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_WAIT   = 2'd2,
    ST_COMMIT = 2'd3
  } fsm_e;

  localparam int KEY_TURN_P = 3;
  localparam int KEY_TURN_M = 2;
  localparam int KEY_FWD    = 1;
  localparam int KEY_BWD    = 0;

  // Two's-complement step per axis, each in {-1, 0, +1}.
  typedef struct packed {
    logic [1:0] dx;
    logic [1:0] dy;
  } delta_t;

  function automatic delta_t dir_delta(input dir_e d);
    delta_t r;
    case (d)
      DIR_E:   r = '{dx: 2'b01, dy: 2'b00};
      DIR_N:   r = '{dx: 2'b00, dy: 2'b11};
      DIR_W:   r = '{dx: 2'b11, dy: 2'b00};
      default: r = '{dx: 2'b00, dy: 2'b01};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/player_target.sv
// Combinational target-cell calculator: current cell + heading (+/- direction).
// Build option PLAYER_WRAP_EN makes the map toroidal instead of walled at the edges.
module player_target
  import player_pkg::*;
#(
  parameter int GRID_W = 32,
  parameter int GRID_H = 32,
  parameter int CORDW  = 6
) (
  input  logic [CORDW-1:0] px,
  input  logic [CORDW-1:0] py,
  input  dir_e             dir,
  input  logic             backward,
  output logic [CORDW-1:0] tx,
  output logic [CORDW-1:0] ty,
  output logic             in_bounds
);

  localparam logic signed [CORDW:0] GW_S = (CORDW+1)'(GRID_W);
  localparam logic signed [CORDW:0] GH_S = (CORDW+1)'(GRID_H);

  delta_t                  w_d;
  logic signed [CORDW:0]   w_ddx, w_ddy, w_dx, w_dy, w_sx, w_sy;

  always_comb begin
    w_d   = dir_delta(dir);
    w_ddx = {{(CORDW-1){w_d.dx[1]}}, w_d.dx};
    w_ddy = {{(CORDW-1){w_d.dy[1]}}, w_d.dy};
    w_dx  = backward ? -w_ddx : w_ddx;
    w_dy  = backward ? -w_ddy : w_ddy;
    w_sx  = $signed({1'b0, px}) + w_dx;
    w_sy  = $signed({1'b0, py}) + w_dy;
  end

`ifdef PLAYER_WRAP_EN
  localparam logic [CORDW-1:0] GW_M1 = CORDW'(GRID_W - 1);
  localparam logic [CORDW-1:0] GH_M1 = CORDW'(GRID_H - 1);

  // A single step can only leave the map by one cell, so only -1 and GRID_* wrap.
  always_comb begin
    if (w_sx[CORDW])       tx = GW_M1;
    else if (w_sx == GW_S) tx = '0;
    else                   tx = w_sx[CORDW-1:0];
    if (w_sy[CORDW])       ty = GH_M1;
    else if (w_sy == GH_S) ty = '0;
    else                   ty = w_sy[CORDW-1:0];
    in_bounds = 1'b1;
  end
`else
  always_comb begin
    tx        = w_sx[CORDW-1:0];
    ty        = w_sy[CORDW-1:0];
    in_bounds = !w_sx[CORDW] && (w_sx < GW_S) && !w_sy[CORDW] && (w_sy < GH_S);
  end
`endif

endmodule

// File: rtl/player_nav_ctrl.sv
// Grid player position/heading controller with wall-map lookup and redraw request.
// Build option PLAYER_WRAP_EN (in player_target) selects a toroidal map.
//
// state     | meaning
// ST_IDLE   | accept keys; turns complete here
// ST_LOOKUP | bump on out-of-bounds target, else issue map read
// ST_WAIT   | count down map latency, then sample wall bit
// ST_COMMIT | move into target cell
module player_nav_ctrl
  import player_pkg::*;
#(
  parameter  int GRID_W    = 32,
  parameter  int GRID_H    = 32,
  parameter  int CORDW     = 6,
  parameter  int MAP_LAT   = 1,
  parameter  int START_X   = 1,
  parameter  int START_Y   = 7,
  parameter  int START_DIR = 0,
  localparam int AW        = $clog2(GRID_W * GRID_H)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       key_pressed,
  input  logic             screen_busy,
  output logic             map_rd_en,
  output logic [AW-1:0]    map_rd_addr,
  input  logic             map_rd_data,
  output logic [CORDW-1:0] px,
  output logic [CORDW-1:0] py,
  output logic [1:0]       direction,
  output logic             refresh,
  output logic             bumped,
  output logic             busy
);

  fsm_e             r_state;
  dir_e             r_dir;
  logic [CORDW-1:0] r_px, r_py, r_tx, r_ty;
  logic             r_inb, r_pending, r_refresh, r_bumped, r_rd_en;
  logic [AW-1:0]    r_addr;
  logic [2:0]       r_cnt;

  logic [CORDW-1:0] w_tx, w_ty;
  logic             w_inb, w_bwd;
  logic [AW-1:0]    w_addr;

  // Forward outranks backward, so the move is backward only when forward is absent.
  assign w_bwd  = !key_pressed[KEY_FWD];
  assign w_addr = AW'(r_ty) * AW'(GRID_W) + AW'(r_tx);

  player_target #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .CORDW  (CORDW)
  ) u_target (
    .px        (r_px),
    .py        (r_py),
    .dir       (r_dir),
    .backward  (w_bwd),
    .tx        (w_tx),
    .ty        (w_ty),
    .in_bounds (w_inb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_dir     <= dir_e'(START_DIR[1:0]);
      r_px      <= CORDW'(START_X);
      r_py      <= CORDW'(START_Y);
      r_tx      <= '0;
      r_ty      <= '0;
      r_inb     <= 1'b0;
      r_pending <= 1'b1;
      r_refresh <= 1'b0;
      r_bumped  <= 1'b0;
      r_rd_en   <= 1'b0;
      r_addr    <= '0;
      r_cnt     <= '0;
    end else begin
      r_rd_en   <= 1'b0;
      r_bumped  <= 1'b0;
      r_refresh <= 1'b0;
      if (r_pending && !screen_busy) begin
        r_refresh <= 1'b1;
        r_pending <= 1'b0;
      end
      // Any later set of r_pending below overrides the clear above.
      case (r_state)
        ST_IDLE: begin
          if (key_pressed[KEY_TURN_P]) begin
            r_dir     <= dir_e'(r_dir + 2'd1);
            r_pending <= 1'b1;
          end else if (key_pressed[KEY_TURN_M]) begin
            r_dir     <= dir_e'(r_dir - 2'd1);
            r_pending <= 1'b1;
          end else if (key_pressed[KEY_FWD] || key_pressed[KEY_BWD]) begin
            r_tx    <= w_tx;
            r_ty    <= w_ty;
            r_inb   <= w_inb;
            r_state <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (!r_inb) begin
            r_bumped <= 1'b1;
            r_state  <= ST_IDLE;
          end else begin
            r_rd_en <= 1'b1;
            r_addr  <= w_addr;
            r_cnt   <= 3'(MAP_LAT);
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 3'd0) begin
            if (map_rd_data) begin
              r_bumped <= 1'b1;
              r_state  <= ST_IDLE;
            end else begin
              r_state <= ST_COMMIT;
            end
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        ST_COMMIT: begin
          r_px      <= r_tx;
          r_py      <= r_ty;
          r_pending <= 1'b1;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign map_rd_en   = r_rd_en;
  assign map_rd_addr = r_addr;
  assign px          = r_px;
  assign py          = r_py;
  assign direction   = r_dir;
  assign refresh     = r_refresh;
  assign bumped      = r_bumped;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_player_nav_ctrl.sv
// Directed bench for player_nav_ctrl with a 32x32 wall map and two-cycle map latency.
module tb_player_nav_ctrl;

  localparam int MAP_LAT = 2;
  localparam int AW      = 10;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [3:0]         key_pressed = 4'b0000;
  logic               screen_busy = 1'b0;
  logic               map_rd_en;
  logic [AW-1:0]      map_rd_addr;
  logic               map_rd_data;
  logic [5:0]         px, py;
  logic [1:0]         direction;
  logic               refresh, bumped, busy;

  logic               wall [0:1023];
  logic [MAP_LAT-1:0] r_pipe;

  int total = 0;
  int bad   = 0;
  int n_ref = 0, n_bump = 0, n_rd = 0;
  int r0, b0, d0, cur_x, exp_x;

  player_nav_ctrl #(.MAP_LAT(MAP_LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_pressed (key_pressed),
    .screen_busy (screen_busy),
    .map_rd_en   (map_rd_en),
    .map_rd_addr (map_rd_addr),
    .map_rd_data (map_rd_data),
    .px          (px),
    .py          (py),
    .direction   (direction),
    .refresh     (refresh),
    .bumped      (bumped),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Wall memory: data appears MAP_LAT cycles after the read strobe.
  always @(posedge clk)
    r_pipe <= {r_pipe[MAP_LAT-2:0], (map_rd_en ? wall[map_rd_addr] : 1'b0)};
  assign map_rd_data = r_pipe[MAP_LAT-1];

  always @(negedge clk) begin
    if (!rst) begin
      n_ref  <= n_ref  + (refresh   === 1'b1 ? 1 : 0);
      n_bump <= n_bump + (bumped    === 1'b1 ? 1 : 0);
      n_rd   <= n_rd   + (map_rd_en === 1'b1 ? 1 : 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(input logic [3:0] k);
    key_pressed = k;
    tick();
    key_pressed = 4'b0000;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) wall[i] = 1'b0;
    r_pipe = '0;

    // 1: reset values and the single post-reset refresh
    rst = 1'b1;
    ticks(3);
    chk("rst_px", px, 1);
    chk("rst_py", py, 7);
    chk("rst_dir", direction, 0);
    chk("rst_busy", busy, 0);
    chk("rst_refresh", refresh, 0);
    chk("rst_bumped", bumped, 0);
    chk("rst_rd_en", map_rd_en, 0);
    rst = 1'b0;
    tick();
    chk("t1_refresh_first", refresh, 1);
    tick();
    chk("t1_refresh_off", refresh, 0);
    ticks(3);
    chk("t1_refresh_count", n_ref, 1);

    // 2: wall at (2,7)
    wall[226] = 1'b1;
    r0 = n_ref; b0 = n_bump;
    pulse(4'b0010);
    chk("t2_busy", busy, 1);
    tick();
    chk("t2_rd_en", map_rd_en, 1);
    chk("t2_addr", map_rd_addr, 226);
    tick();
    chk("t2_rd_en_pulse", map_rd_en, 0);
    tick();
    chk("t2_bump_early", bumped, 0);
    tick();
    chk("t2_bumped", bumped, 1);
    chk("t2_idle", busy, 0);
    tick();
    chk("t2_bump_pulse", bumped, 0);
    chk("t2_px", px, 1);
    ticks(3);
    chk("t2_no_refresh", n_ref, r0);
    chk("t2_bump_count", n_bump, b0 + 1);

    // 3: free (2,7), commit five cycles after the key
    wall[226] = 1'b0;
    r0 = n_ref;
    pulse(4'b0010);
    ticks(4);
    chk("t3_px_early", px, 1);
    tick();
    chk("t3_px", px, 2);
    chk("t3_idle", busy, 0);
    tick();
    chk("t3_refresh", refresh, 1);
    ticks(2);
    chk("t3_refresh_count", n_ref, r0 + 1);

    // 4: walk to (0,7) facing W, then step off the left edge
    pulse(4'b1000);
    chk("t4_turn1", direction, 1);
    pulse(4'b1000);
    chk("t4_turn2", direction, 2);
    ticks(2);
    pulse(4'b0010);
    ticks(6);
    pulse(4'b0010);
    ticks(6);
    chk("t4_setup_px", px, 0);
    b0 = n_bump; d0 = n_rd;
`ifdef PLAYER_WRAP_EN
    pulse(4'b0010);
    tick();
    chk("t4_wrap_rd_en", map_rd_en, 1);
    chk("t4_wrap_addr", map_rd_addr, 255);
    ticks(4);
    chk("t4_wrap_px", px, 31);
    chk("t4_wrap_no_bump", n_bump, b0);
    cur_x = 31;
    exp_x = 0;
`else
    pulse(4'b0010);
    tick();
    chk("t4_edge_bumped", bumped, 1);
    chk("t4_edge_idle", busy, 0);
    ticks(4);
    chk("t4_edge_no_read", n_rd, d0);
    chk("t4_edge_bump_count", n_bump, b0 + 1);
    chk("t4_edge_px", px, 0);
    cur_x = 0;
    exp_x = 1;
`endif

    // 5: key priority and refresh coalescing
    d0 = n_rd;
    pulse(4'b1010);
    chk("t5_prio_dir", direction, 3);
    ticks(6);
    chk("t5_prio_px", px, cur_x);
    chk("t5_prio_no_read", n_rd, d0);
    chk("t5_prio_idle", busy, 0);
    pulse(4'b0101);
    chk("t5_prio_m_dir", direction, 2);
    ticks(4);
    chk("t5_prio_m_px", px, cur_x);
    ticks(2);
    r0 = n_ref;
    screen_busy = 1'b1;
    pulse(4'b1000);
    ticks(2);
    pulse(4'b0100);
    ticks(4);
    chk("t5_no_refresh_busy", n_ref, r0);
    screen_busy = 1'b0;
    ticks(4);
    chk("t5_coalesced", n_ref, r0 + 1);

    // commit lands on the same edge as a refresh: pending survives
    r0 = n_ref;
    screen_busy = 1'b1;
    pulse(4'b1000);
    pulse(4'b0100);
    pulse(4'b0001);
    ticks(4);
    screen_busy = 1'b0;
    tick();
    chk("t5_bwd_px", px, exp_x);
    chk("t5_refresh_a", refresh, 1);
    tick();
    chk("t5_refresh_b", refresh, 1);
    tick();
    chk("t5_refresh_off", refresh, 0);
    chk("t5_refresh_count", n_ref, r0 + 2);

    // 6: reset during WAIT, then keys while busy
    b0 = n_bump;
    pulse(4'b0010);
    ticks(2);
    chk("t6_busy_wait", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_px", px, 1);
    chk("t6_rst_py", py, 7);
    chk("t6_rst_dir", direction, 0);
    chk("t6_rst_idle", busy, 0);
    ticks(6);
    chk("t6_no_bump", n_bump, b0);
    chk("t6_no_commit", px, 1);
    pulse(4'b0010);
    tick();
    pulse(4'b1000);
    pulse(4'b0010);
    ticks(4);
    chk("t6_move_px", px, 2);
    chk("t6_turn_ignored", direction, 0);
    ticks(8);
    chk("t6_no_queue_px", px, 2);
    chk("t6_no_queue_dir", direction, 0);
    pulse(4'b0100);
    chk("t6_turn_mod", direction, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
